// File: rtl/dmem_arbiter.sv
// Data memory arbiter: the pipeline memory stage owns the single-port data memory by
// default; a DMA port gets idle cycles plus a periodic forced grant that stalls the pipeline.
module dmem_arbiter #(
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int COOL_CYCLES  = 1
) (
  input  logic              clk,
  input  logic              rst,
  // pipeline memory stage
  input  logic              MemReqM,
  input  logic              MemWriteM,
  input  logic [DATA_W-1:0] ALU_ResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              StallM,
  // DMA / loader port
  input  logic              dma_valid,
  input  logic              dma_we,
  input  logic [DATA_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ready,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  // data memory
  output logic [DATA_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_WD,
  output logic              mem_WE,
  input  logic [DATA_W-1:0] mem_RD
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int CW = (COOL_CYCLES > 1) ? $clog2(COOL_CYCLES) : 1;

  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [CW-1:0] COOL_INIT  = CW'(COOL_CYCLES - 1);

  localparam logic [0:0] ARB  = 1'b0;
  localparam logic [0:0] COOL = 1'b1;

  logic [0:0]    state;
  logic [SW-1:0] starve_cnt;
  logic [CW-1:0] cool_cnt;
  logic          force_ok;
  logic          dma_gnt;

  // Grant logic. Qualifying with rst keeps the memory and both requesters quiet
  // for as long as reset is held, whatever the inputs are doing.
  always_comb begin
    force_ok = (state == ARB) && (starve_cnt == STARVE_MAX);
    dma_gnt  = rst && dma_valid && (!MemReqM || force_ok);
  end

  assign dma_ready = dma_gnt;
  assign StallM    = rst && MemReqM && dma_gnt;
  assign ReadDataM = mem_RD;

  always_comb begin
    if (dma_gnt) begin
      mem_A  = dma_addr;
      mem_WD = dma_wdata;
      mem_WE = dma_we;
    end else begin
      mem_A  = ALU_ResultM;
      mem_WD = WriteDataM;
      mem_WE = rst && MemWriteM && MemReqM;
    end
  end

  // Starvation counter: counts consecutive cycles a valid DMA request was refused.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (!dma_valid || dma_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != STARVE_MAX) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // A forced grant (the only way StallM rises) opens a cool-down window in which
  // the stalled pipeline access is guaranteed to reach memory.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ARB;
      cool_cnt <= '0;
    end else begin
      case (state)
        ARB: begin
          if (StallM) begin
            state    <= COOL;
            cool_cnt <= COOL_INIT;
          end
        end
        COOL: begin
          if (cool_cnt == '0) begin
            state <= ARB;
          end else begin
            cool_cnt <= cool_cnt - CW'(1);
          end
        end
        default: begin
          state    <= ARB;
          cool_cnt <= '0;
        end
      endcase
    end
  end

  // DMA read return path: one-cycle latency, data held between reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else if (dma_gnt && !dma_we) begin
      dma_rvalid <= 1'b1;
      dma_rdata  <= mem_RD;
    end else begin
      dma_rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small behavioural data memory.
module tb_dmem_arbiter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          MemReqM, MemWriteM;
  logic [DW-1:0] ALU_ResultM, WriteDataM, ReadDataM;
  logic          StallM;
  logic          dma_valid, dma_we, dma_ready, dma_rvalid;
  logic [DW-1:0] dma_addr, dma_wdata, dma_rdata;
  logic [DW-1:0] mem_A, mem_WD, mem_RD;
  logic          mem_WE;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] mem [0:255];

  dmem_arbiter #(.DATA_W(DW), .STARVE_LIMIT(4), .COOL_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .MemReqM(MemReqM), .MemWriteM(MemWriteM), .ALU_ResultM(ALU_ResultM),
    .WriteDataM(WriteDataM), .ReadDataM(ReadDataM), .StallM(StallM),
    .dma_valid(dma_valid), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ready(dma_ready), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
    .mem_A(mem_A), .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
  );

  always #5 clk = ~clk;

  // Combinational-read, synchronous-write memory model.
  assign mem_RD = mem[mem_A[7:0]];
  always @(posedge clk) if (mem_WE) mem[mem_A[7:0]] <= mem_WD;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pipe(input logic req, input logic we, input logic [DW-1:0] a,
                          input logic [DW-1:0] d);
    MemReqM = req; MemWriteM = we; ALU_ResultM = a; WriteDataM = d;
  endtask

  task automatic set_dma(input logic v, input logic we, input logic [DW-1:0] a,
                         input logic [DW-1:0] d);
    dma_valid = v; dma_we = we; dma_addr = a; dma_wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic prev_stall;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;

    // 1. Reset holds every request path quiet.
    rst = 1'b0;
    set_pipe(1'b1, 1'b1, 32'h40, 32'h1234);
    set_dma(1'b1, 1'b1, 32'h44, 32'h5678);
    #3;
    check("rst_ready_pipe", dma_ready, 0);
    check("rst_stall", StallM, 0);
    check("rst_we_pipe", mem_WE, 0);
    check("rst_rvalid", dma_rvalid, 0);
    set_pipe(1'b0, 1'b0, 32'h40, 32'h1234);
    #1;
    check("rst_ready_idle", dma_ready, 0);
    check("rst_we_idle", mem_WE, 0);
    tick();
    tick();
    rst = 1'b1;
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("post_rst_rdata", dma_rdata, 0);
    check("post_rst_rvalid", dma_rvalid, 0);
    tick();

    // 2. Idle pipeline: back-to-back DMA write then read.
    set_dma(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    #1;
    check("t2_wr_ready", dma_ready, 1);
    check("t2_wr_stall", StallM, 0);
    check("t2_wr_we", mem_WE, 1);
    check("t2_wr_addr", mem_A, 32'h10);
    tick();
    set_dma(1'b1, 1'b0, 32'h10, 32'h0);
    #1;
    check("t2_rd_ready", dma_ready, 1);
    check("t2_rd_we", mem_WE, 0);
    tick();
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    check("t2_rvalid", dma_rvalid, 1);
    check("t2_rdata", dma_rdata, 32'hDEADBEEF);
    tick();
    check("t2_rvalid_pulse", dma_rvalid, 0);
    check("t2_rdata_hold", dma_rdata, 32'hDEADBEEF);

    // 3/4. Sustained contention: forced grant every 5th cycle, never two stalls in a row.
    set_pipe(1'b1, 1'b0, 32'h10, 32'h0);
    set_dma(1'b1, 1'b1, 32'h30, 32'hCAFE0000);
    prev_stall = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #1;
      check($sformatf("t4_ready_%0d", i), dma_ready, (i % 5 == 4) ? 1 : 0);
      check($sformatf("t4_stall_%0d", i), StallM, (i % 5 == 4) ? 1 : 0);
      check($sformatf("t4_no_double_%0d", i), prev_stall && StallM, 0);
      check($sformatf("t4_addr_%0d", i), mem_A, (i % 5 == 4) ? 32'h30 : 32'h10);
      prev_stall = StallM;
      tick();
    end

    // 5. Forced DMA read collides with pipeline store to the same word.
    set_pipe(1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    tick();
    set_dma(1'b1, 1'b1, 32'h20, 32'h11112222);
    #1;
    check("t5_seed_ready", dma_ready, 1);
    tick();
    set_pipe(1'b1, 1'b0, 32'h20, 32'h0);
    set_dma(1'b1, 1'b0, 32'h20, 32'h0);
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("t5_wait_ready_%0d", i), dma_ready, 0);
      check($sformatf("t5_wait_rd_%0d", i), ReadDataM, 32'h11112222);
      tick();
    end
    set_pipe(1'b1, 1'b1, 32'h20, 32'h55);
    #1;
    check("t5_force_ready", dma_ready, 1);
    check("t5_force_stall", StallM, 1);
    check("t5_force_we", mem_WE, 0);
    tick();
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    check("t5_rvalid", dma_rvalid, 1);
    check("t5_rdata_old", dma_rdata, 32'h11112222);
    check("t5_store_stall", StallM, 0);
    check("t5_store_we", mem_WE, 1);
    check("t5_store_wd", mem_WD, 32'h55);
    tick();
    set_pipe(1'b1, 1'b0, 32'h20, 32'h0);
    #1;
    check("t5_load_new", ReadDataM, 32'h55);
    tick();

    // 6a. Reset right after a forced read is accepted: the return pulse is lost.
    set_dma(1'b1, 1'b0, 32'h10, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    check("t6_force_stall", StallM, 1);
    tick();
    check("t6_rvalid_pre", dma_rvalid, 1);
    rst = 1'b0;
    #1;
    check("t6_rvalid_rst", dma_rvalid, 0);
    check("t6_rdata_rst", dma_rdata, 0);
    check("t6_stall_rst", StallM, 0);
    check("t6_ready_rst", dma_ready, 0);
    tick();
    rst = 1'b1;

    // 6b. Reset while starving clears the counter: a full STARVE_LIMIT wait follows.
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("t6_resume_ready_%0d", i), dma_ready, (i == 4) ? 1 : 0);
      check($sformatf("t6_resume_stall_%0d", i), StallM, (i == 4) ? 1 : 0);
      tick();
    end

    set_pipe(1'b0, 1'b0, 32'h0, 32'h0);
    set_dma(1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
